hazard_ctrl: RTL

- Hazard and stall controller for the 5-stage RV32I pipeline.
- Inspects the instructions held in the stage1/stage2/stage3 pipeline registers plus the EX-stage branch resolution and the data-memory handshake.
- Drives the stall, hold, flush and redirect controls consumed by the stage0–stage4 pipeline registers.
- Owns a small state machine for load-use bubbles, mispredict squashes, memory-wait freezes and a memory timeout.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_decode.sv | 28 ++
 rtl/hazard_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared opcode constants, NOP encoding and controller state type for the RV32I hazard controller.
// Optional feature macro used by hazard_ctrl: HAZARD_PERF_CNT_EN.
package hazard_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INST = 32'h00000033;

  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH, MEMWAIT} hz_state_t;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Per-instruction register-usage decoder: source/destination fields plus use/valid flags.
// Purely combinational, zero latency, no backpressure.
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_rs1_use,
  output logic        o_rs2_use,
  output logic        o_rd_vld
);

  logic [6:0] w_op;
  logic       w_unused;

  assign w_op      = i_inst[6:0];
  assign o_rs1     = i_inst[19:15];
  assign o_rs2     = i_inst[24:20];
  assign o_rd      = i_inst[11:7];
  assign o_rs1_use = !(w_op inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign o_rs2_use = w_op inside {OP_RTYPE, OP_STORE, OP_BRANCH};
  // x0 is never a real destination, so it can never create a dependency
  assign o_rd_vld  = !(w_op inside {OP_STORE, OP_BRANCH}) && (o_rd != 5'd0);
  assign w_unused  = ^{i_inst[31:25], i_inst[14:12]};

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32I pipeline; state advances on negedge clk like the pipe regs.
// Optional perf counters (cnt_ldstall/cnt_flush/cnt_memwait) exist only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     id_inst,
  input  logic [31:0]     ex_inst,
  input  logic [31:0]     mem_inst,
  input  logic            ex_mispredict,
  input  logic [XLEN-1:0] ex_target,
  input  logic            dmem_ready,
  output logic            pc_stall,
  output logic            ifid_stall,
  output logic            idex_bubble,
  output logic            freeze_all,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]     cnt_ldstall,
  output logic [31:0]     cnt_flush,
  output logic [31:0]     cnt_memwait
`endif
);

  logic [4:0] w_id_rs1, w_id_rs2, w_id_rd, w_ex_rs1, w_ex_rs2, w_ex_rd;
  logic       w_id_rs1_use, w_id_rs2_use, w_id_rd_vld;
  logic       w_ex_rs1_use, w_ex_rs2_use, w_ex_rd_vld;

  hazard_decode u_dec_id (
    .i_inst(id_inst), .o_rs1(w_id_rs1), .o_rs2(w_id_rs2), .o_rd(w_id_rd),
    .o_rs1_use(w_id_rs1_use), .o_rs2_use(w_id_rs2_use), .o_rd_vld(w_id_rd_vld)
  );

  hazard_decode u_dec_ex (
    .i_inst(ex_inst), .o_rs1(w_ex_rs1), .o_rs2(w_ex_rs2), .o_rd(w_ex_rd),
    .o_rs1_use(w_ex_rs1_use), .o_rs2_use(w_ex_rs2_use), .o_rd_vld(w_ex_rd_vld)
  );

  hz_state_t       r_state, w_state_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic            r_pending, w_pending_nxt;
  logic [XLEN-1:0] r_redirect_pc, w_rpc_nxt;
  logic            r_mem_err, w_err_set;
  logic            w_pc_stall, w_ifid_stall, w_idex_bubble, w_freeze, w_pc_redirect;
  logic            w_rpc_from_ex, w_ld_bubble;
  logic            w_load_use, w_mem_pend, w_timeout;
  logic            w_unused;

  assign w_load_use = (ex_inst[6:0] == OP_LOAD) && w_ex_rd_vld &&
                      ((w_id_rs1_use && (w_id_rs1 == w_ex_rd)) ||
                       (w_id_rs2_use && (w_id_rs2 == w_ex_rd)));
  assign w_mem_pend = is_mem_op(mem_inst[6:0]) && !dmem_ready;
  assign w_timeout  = (r_to_cnt == TO_W'(MEM_TIMEOUT));
  assign w_unused   = ^{mem_inst[31:7], w_id_rd, w_id_rd_vld, w_ex_rs1, w_ex_rs2,
                        w_ex_rs1_use, w_ex_rs2_use};

  always_comb begin
    w_state_nxt   = r_state;
    w_to_cnt_nxt  = '0;
    w_pending_nxt = r_pending;
    w_rpc_nxt     = r_redirect_pc;
    w_err_set     = 1'b0;
    w_pc_stall    = 1'b0;
    w_ifid_stall  = 1'b0;
    w_idex_bubble = 1'b0;
    w_freeze      = 1'b0;
    w_pc_redirect = 1'b0;
    w_rpc_from_ex = 1'b0;
    w_ld_bubble   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_pend) begin
          w_freeze    = 1'b1;
          w_state_nxt = MEMWAIT;
          if (ex_mispredict) begin
            w_rpc_nxt     = ex_target;
            w_pending_nxt = 1'b1;
          end
        end else if (ex_mispredict) begin
          w_pc_redirect = 1'b1;
          w_rpc_from_ex = 1'b1;
          w_rpc_nxt     = ex_target;
          w_ifid_stall  = 1'b1;
          w_idex_bubble = 1'b1;
          w_state_nxt   = FLUSH;
        end else if (w_load_use) begin
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_bubble = 1'b1;
          w_ld_bubble   = 1'b1;
          w_state_nxt   = LDSTALL;
        end
      end
      LDSTALL: begin
        // The stalled load has just reached MEM; a slow memory still has to freeze here
        if (w_mem_pend) begin
          w_freeze    = 1'b1;
          w_state_nxt = MEMWAIT;
        end else begin
          w_state_nxt = RUN;
        end
      end
      FLUSH: begin
        w_ifid_stall = 1'b1;
        w_state_nxt  = RUN;
      end
      MEMWAIT: begin
        if (dmem_ready) begin
          if (r_pending) begin
            // Deferred mispredict: wrong-path ID/EX contents advance on this edge, so squash them too
            w_pc_redirect = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_bubble = 1'b1;
            w_pending_nxt = 1'b0;
            w_state_nxt   = FLUSH;
          end else begin
            w_state_nxt = RUN;
          end
        end else if (w_timeout) begin
          w_err_set     = 1'b1;
          w_pending_nxt = 1'b0;
          w_state_nxt   = RUN;
        end else begin
          w_freeze     = 1'b1;
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_to_cnt      <= '0;
      r_pending     <= 1'b0;
      r_redirect_pc <= '0;
      r_mem_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_pending     <= w_pending_nxt;
      r_redirect_pc <= w_rpc_nxt;
      r_mem_err     <= r_mem_err | w_err_set;
    end
  end

  assign freeze_all  = w_freeze && !rst;
  assign pc_stall    = w_pc_stall && !w_freeze && !rst;
  assign ifid_stall  = w_ifid_stall && !w_freeze && !rst;
  assign idex_bubble = w_idex_bubble && !w_freeze && !rst;
  assign pc_redirect = w_pc_redirect && !w_freeze && !rst;
  assign redirect_pc = rst ? '0 : (w_rpc_from_ex ? ex_target : r_redirect_pc);
  assign mem_err     = r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_cnt_ldstall, r_cnt_flush, r_cnt_memwait;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_ldstall <= '0;
      r_cnt_flush   <= '0;
      r_cnt_memwait <= '0;
    end else begin
      if (w_ld_bubble)          r_cnt_ldstall <= r_cnt_ldstall + 32'd1;
      if (w_pc_redirect)        r_cnt_flush   <= r_cnt_flush + 32'd1;
      if (r_state == MEMWAIT)   r_cnt_memwait <= r_cnt_memwait + 32'd1;
    end
  end

  assign cnt_ldstall = r_cnt_ldstall;
  assign cnt_flush   = r_cnt_flush;
  assign cnt_memwait = r_cnt_memwait;
`endif

endmodule
